reg_seq_ctrl: RTL and testbench

- Instruction sequencer for the 4x8 register file and the external ALU.
- Accepts one 16-bit instruction at a time over a valid/ready handshake.
- Drives the register file read/write controls (DIR_A, DIR_B, DIR_WR, DI, EN) and the ALU operation select, then writes the ALU result back.
- Sits between the instruction source (testbench or fetch unit) and the register file + ALU datapath.

---
 rtl/reg_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_reg_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_seq_ctrl.sv
// Instruction sequencer for a 4x8 register file and an external ALU.
// Each instruction moves through IDLE -> (RD -> EX) -> (WB) -> IDLE.
module reg_seq_ctrl #(
  parameter int DW = 8,
  parameter int AW = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   INSTR,
  input  logic          INSTR_VALID,
  output logic          INSTR_READY,
  output logic [AW-1:0] DIR_A,
  output logic [AW-1:0] DIR_B,
  output logic [AW-1:0] DIR_WR,
  output logic [DW-1:0] DI,
  output logic          EN,
  input  logic [DW-1:0] DOA,
  input  logic [DW-1:0] DOB,
  output logic [2:0]    ALU_OP,
  input  logic [DW-1:0] ALU_RES,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_VALID,
  output logic          ZF,
  output logic          ILLEGAL,
  output logic [CW-1:0] INSTR_CNT
);

  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      op_reg;
  logic [AW-1:0]   rd_reg;
  logic            accept;
  logic            retire;

  logic [3:0]      in_op;
  logic            in_nop, in_ldi, in_mov, in_out, in_alu, in_ill;
  logic            ex_mov, ex_out, ex_alu;

  assign in_op  = INSTR[15:12];
  assign in_nop = (in_op == 4'd0);
  assign in_ldi = (in_op == 4'd1);
  assign in_mov = (in_op == 4'd2);
  assign in_out = (in_op == 4'd3);
  assign in_alu = (in_op[3:2] == 2'b01) || (in_op[3:2] == 2'b10);
  assign in_ill = (in_op[3:2] == 2'b11);

  assign ex_mov = (op_reg == 4'd2);
  assign ex_out = (op_reg == 4'd3);
  assign ex_alu = (op_reg[3:2] == 2'b01) || (op_reg[3:2] == 2'b10);

  assign accept = INSTR_VALID && (state_reg == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (in_ldi) begin
            state_next = WB;
          end else if (in_mov || in_out || in_alu) begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = EX;
      EX:      state_next = ex_out ? IDLE : WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; opcode 4..11 maps to op-4, which mod 8 is just bit 2 flipped
  always_comb begin
    INSTR_READY = (state_reg == IDLE);
    EN          = (state_reg == WB);
    ALU_OP      = 3'd0;
    if (state_reg == EX && ex_alu) begin
      ALU_OP = op_reg[2:0] ^ 3'b100;
    end
  end

  assign retire = (accept && (in_nop || in_ill)) ||
                  (state_reg == EX && ex_out) ||
                  (state_reg == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= 4'd0;
      rd_reg     <= '0;
      DIR_A      <= '0;
      DIR_B      <= '0;
      DIR_WR     <= '0;
      DI         <= '0;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
      ZF         <= 1'b0;
      ILLEGAL    <= 1'b0;
      INSTR_CNT  <= '0;
    end else begin
      DOUT_VALID <= 1'b0;
      if (accept) begin
        op_reg <= in_op;
        rd_reg <= INSTR[10 +: AW];
        if (in_mov || in_out || in_alu) begin
          DIR_A <= INSTR[8 +: AW];
          DIR_B <= INSTR[6 +: AW];
        end
        if (in_ldi) begin
          DIR_WR <= INSTR[10 +: AW];
          DI     <= DW'(INSTR[7:0]);
        end
        if (in_ill) begin
          ILLEGAL <= 1'b1;
        end
      end
      if (state_reg == EX) begin
        if (ex_out) begin
          DOUT       <= DOA;
          DOUT_VALID <= 1'b1;
        end else if (ex_mov) begin
          DIR_WR <= rd_reg;
          DI     <= DOA;
        end else if (ex_alu) begin
          DIR_WR <= rd_reg;
          DI     <= ALU_RES;
        end
      end
      if (state_reg == WB) begin
        ZF <= (DI == '0);
      end
      if (retire) begin
        INSTR_CNT <= INSTR_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl: register file + ALU model around the DUT, directed
// instructions push expected writes/outputs into queues, a monitor pops them.
module tb_reg_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] INSTR = 16'h0000;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic [1:0]  DIR_A, DIR_B, DIR_WR;
  logic [7:0]  DI;
  logic        EN;
  logic [7:0]  DOA = 8'h00;
  logic [7:0]  DOB = 8'h00;
  logic [2:0]  ALU_OP;
  logic [7:0]  ALU_RES;
  logic [7:0]  DOUT;
  logic        DOUT_VALID;
  logic        ZF;
  logic        ILLEGAL;
  logic [7:0]  INSTR_CNT;

  reg_seq_ctrl #(.DW(8), .AW(2), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .DIR_A(DIR_A), .DIR_B(DIR_B), .DIR_WR(DIR_WR), .DI(DI), .EN(EN),
    .DOA(DOA), .DOB(DOB), .ALU_OP(ALU_OP), .ALU_RES(ALU_RES),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .ZF(ZF), .ILLEGAL(ILLEGAL),
    .INSTR_CNT(INSTR_CNT)
  );

  always #5 clk = ~clk;

  // Register file: registered read ports, write when EN
  logic [7:0] mem [4];
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
  end
  always @(posedge clk) begin
    if (EN) begin
      mem[DIR_WR] <= DI;
    end else begin
      DOA <= mem[DIR_A];
      DOB <= mem[DIR_B];
    end
  end

  always_comb begin
    case (ALU_OP)
      3'd0:    ALU_RES = DOA + DOB;
      3'd1:    ALU_RES = DOA - DOB;
      3'd2:    ALU_RES = DOA & DOB;
      3'd3:    ALU_RES = DOA | DOB;
      3'd4:    ALU_RES = DOA ^ DOB;
      3'd5:    ALU_RES = ~DOA;
      3'd6:    ALU_RES = DOA << 1;
      default: ALU_RES = DOA >> 1;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int data; int cyc;} exp_t;
  exp_t wq[$];
  exp_t oq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write pulse and every DOUT pulse must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (EN) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got r%0d<=0x%02h expected no write (cycle %0d)", DIR_WR, DI, cyc);
        end else begin
          exp_t e;
          e = wq.pop_front();
          $display("write r%0d <= 0x%02h at cycle %0d", DIR_WR, DI, cyc);
          chk("wr_addr", int'(DIR_WR), e.addr);
          chk("wr_data", int'(DI), e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      if (DOUT_VALID) begin
        if (oq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_dout: got 0x%02h expected no output (cycle %0d)", DOUT, cyc);
        end else begin
          exp_t e;
          e = oq.pop_front();
          $display("dout 0x%02h at cycle %0d", DOUT, cyc);
          chk("dout_data", int'(DOUT), e.data);
          chk("dout_cycle", cyc, e.cyc);
        end
      end
    end
  end

  function automatic logic [15:0] op3(input int op, input int rd, input int rs1, input int rs2);
    return {4'(op), 2'(rd), 2'(rs1), 2'(rs2), 6'd0};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {4'h1, 2'(rd), 2'b00, 8'(imm)};
  endfunction

  // Called at a negedge with INSTR_READY high; returns at a negedge with it high again.
  // exp_val is the hand-computed write-back value (or DOUT for OUT).
  task automatic issue(input logic [15:0] ins, input int exp_val);
    int op;
    int busy;
    op = int'(ins[15:12]);
    busy = 0;
    if (op == 1) begin
      busy = 1;
      wq.push_back('{int'(ins[11:10]), exp_val, cyc + 1});
    end else if (op == 3) begin
      busy = 2;
      oq.push_back('{0, exp_val, cyc + 3});
    end else if (op >= 2 && op <= 11) begin
      busy = 3;
      wq.push_back('{int'(ins[11:10]), exp_val, cyc + 3});
    end
    INSTR = ins;
    INSTR_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < busy; i++) begin
      chk("ready_busy", int'(INSTR_READY), 0);
      INSTR = ~ins;
      @(negedge clk);
    end
    chk("ready_idle", int'(INSTR_READY), 1);
  endtask

  task automatic drain();
    INSTR_VALID = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    INSTR_VALID = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_en", int'(EN), 0);
    chk("rst_dout_valid", int'(DOUT_VALID), 0);
    chk("rst_zf", int'(ZF), 0);
    chk("rst_illegal", int'(ILLEGAL), 0);
    chk("rst_cnt", int'(INSTR_CNT), 0);
    chk("rst_di", int'(DI), 0);
    chk("rst_dir_wr", int'(DIR_WR), 0);
    chk("rst_alu_op", int'(ALU_OP), 0);
    rst_n = 1'b1;
    chk("ready_after_rst", int'(INSTR_READY), 1);

    // LDI to each register, then OUT each one
    issue(ldi(0, 8'h11), 8'h11);
    issue(ldi(1, 8'h22), 8'h22);
    issue(ldi(2, 8'h33), 8'h33);
    issue(ldi(3, 8'h44), 8'h44);
    issue(op3(3, 0, 0, 0), 8'h11);
    issue(op3(3, 0, 1, 0), 8'h22);
    issue(op3(3, 0, 2, 0), 8'h33);
    issue(op3(3, 0, 3, 0), 8'h44);
    drain();
    chk("cnt_after_ldi_out", int'(INSTR_CNT), 8);

    // ALU path: add and xor
    issue(ldi(1, 8'h05), 8'h05);
    issue(ldi(2, 8'h03), 8'h03);
    issue(op3(4, 3, 1, 2), 8'h08);
    issue(op3(8, 0, 1, 2), 8'h06);
    issue(op3(3, 0, 3, 0), 8'h08);
    drain();
    chk("zf_after_add", int'(ZF), 0);

    // Dependencies and the zero flag
    issue(ldi(0, 8'h00), 8'h00);
    issue(op3(2, 1, 0, 0), 8'h00);
    drain();
    chk("zf_after_mov_zero", int'(ZF), 1);
    issue(op3(4, 0, 0, 0), 8'h00);
    issue(ldi(0, 8'h80), 8'h80);
    drain();
    chk("zf_after_ldi_80", int'(ZF), 0);
    issue(op3(4, 0, 0, 0), 8'h00);
    drain();
    chk("zf_after_wrap_add", int'(ZF), 1);
    chk("cnt_before_handshake", int'(INSTR_CNT), 18);

    // Handshake: VALID held high over six back-to-back instructions
    issue(ldi(0, 8'h0A), 8'h0A);
    issue(ldi(1, 8'h0B), 8'h0B);
    issue(op3(4, 2, 0, 1), 8'h15);
    issue(op3(2, 3, 2, 0), 8'h15);
    issue(op3(3, 0, 3, 0), 8'h15);
    issue(op3(3, 0, 0, 0), 8'h0A);
    drain();
    chk("cnt_after_handshake", int'(INSTR_CNT), 24);
    chk("illegal_before", int'(ILLEGAL), 0);

    // Illegal opcode is sticky and never writes
    issue(16'hF123, 0);
    drain();
    chk("illegal_set", int'(ILLEGAL), 1);
    issue(16'h0000, 0);
    drain();
    chk("illegal_sticky", int'(ILLEGAL), 1);
    chk("cnt_after_illegal", int'(INSTR_CNT), 26);

    // Counter wrap from zero
    do_reset();
    chk("illegal_cleared", int'(ILLEGAL), 0);
    chk("cnt_cleared", int'(INSTR_CNT), 0);
    for (int i = 1; i <= 256; i++) begin
      issue(16'h0000, 0);
      chk("cnt_wrap", int'(INSTR_CNT), i % 256);
    end
    drain();

    // Reset during EX of an ALU op aborts it without a write
    issue(ldi(2, 8'h5A), 8'h5A);
    INSTR = op3(4, 2, 0, 1);
    INSTR_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    INSTR_VALID = 1'b0;
    @(posedge clk);
    #1;
    chk("ex_ready_low", int'(INSTR_READY), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_en", int'(EN), 0);
    chk("midrst_dir_a", int'(DIR_A), 0);
    chk("midrst_dir_b", int'(DIR_B), 0);
    chk("midrst_di", int'(DI), 0);
    chk("midrst_cnt", int'(INSTR_CNT), 0);
    chk("midrst_ready", int'(INSTR_READY), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("ready_after_midrst", int'(INSTR_READY), 1);
    issue(op3(3, 0, 2, 0), 8'h5A);
    drain();

    chk("write_queue_empty", wq.size(), 0);
    chk("out_queue_empty", oq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
